multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle control FSM that drives the control inputs of the CPU datapath (RegWrite, PCSrc, ALUSrc,
//  ALU_operation, write, MemtoReg) from the fetched instruction and the ALU status flags.
//  Sits beside the datapath: consumes inst_in (ROM output) and status, adds PC enable, trap and retire signals.
//  Supports RV32I R-type ALU, I-type ALU, LW, SW, and BEQ/BNE/BLT/BGE; all other encodings trap.
// PARAMETERS
//  MEM_LAT  1  cycles a load stays in MEM before WB (1..15); stores always use 1 MEM cycle
// PORTS
//  clk            input   1   system clock, all state on rising edge
//  reset          input   1   asynchronous, active-low reset
//  run            input   1   FETCH advances only while run=1 (stall/hold request)
//  inst_in        input   32  instruction from ROM, valid in the cycle after FETCH
//  status         input   4   ALU flags {V,C,N,Z} = status[3:0]
//  RegWrite       output  1   register file write enable
//  PCSrc          output  1   0: PC+4, 1: PC+imm
//  ALUSrc         output  1   0: ALU B from reg rs2, 1: from immediate
//  ALU_operation  output  5   ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9
//  write          output  1   data RAM write enable
//  MemtoReg       output  1   0: writeback from RAM read data, 1: from ALU result
//  pc_write       output  1   PC load enable, exactly one pulse per retired instruction
//  retired        output  1   1-cycle pulse, coincident with pc_write
//  illegal        output  1   high while in TRAP
// BEHAVIOUR
//  States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset: FETCH, ir=0, mem counter=0, every output 0.
//  Outputs decoded from the current state and the latched ir only; no combinational path from inst_in or run.
//  FETCH: -> DECODE when run=1, else hold. DECODE: ir<=inst_in; -> EXEC, or -> TRAP if unsupported.
//  Unsupported: opcode not in {0110011,0010011,0000011,0100011,1100011}; LW funct3!=010; SW funct3!=010;
//   branch funct3 not in {000,001,100,101}; R-type funct7 other than 0000000 or 0100000 (SUB/SRA only).
//  ALU_operation: R/I from funct3 (000 ADD, or SUB if R and funct7[5]; 111 AND; 110 OR; 100 XOR; 001 SLL;
//   101 SRL/SRA by funct7[5]; 010 SLT; 011 SLTU); load/store -> ADD; branch -> SUB. Held from EXEC to end of instruction.
//  ALUSrc=1 for I-ALU, LW, SW in EXEC/MEM/WB; 0 otherwise.
//  EXEC: R/I -> WB; LW, SW -> MEM; branch: evaluate status, pc_write=1, retired=1, PCSrc=taken, -> FETCH.
//   taken: BEQ Z; BNE !Z; BLT N^V; BGE !(N^V). status sampled in EXEC only.
//  MEM (SW): write=1 for exactly one cycle, pc_write=1, retired=1, PCSrc=0, -> FETCH.
//  MEM (LW): write=0, stay MEM_LAT cycles (counter), then -> WB.
//  WB: RegWrite=1 one cycle, MemtoReg=0 for LW / 1 for R,I; pc_write=1, retired=1, PCSrc=0; -> FETCH.
//  Latency (cycles, run held 1): R/I 4; branch 3; SW 4; LW 4+MEM_LAT.
//  Outside listed states every enable (RegWrite, write, pc_write, retired) is 0; PCSrc=0 unless branch EXEC.
//  TRAP: absorbing; illegal=1, all enables 0; leaves only via reset.
//  run is only examined in FETCH; dropping run mid-instruction does not stall it.
//  Reset asserted mid-instruction: immediate return to FETCH, outputs 0; no partial write or PC update survives.
//  ir=0 (opcode 0000000) is unsupported, so a zero instruction word traps.
// TESTING
//  add x3,x1,x2 (0x002081B3), run=1 -> ALU_operation=0, ALUSrc=0; RegWrite=1, MemtoReg=1, pc_write=1 in cycle 4 only.
//  lw x5,8(x0) (0x00802283), MEM_LAT=3 -> write=0 throughout, RegWrite=1 & MemtoReg=0 in cycle 7; ALUSrc=1, op=0.
//  sw x5,4(x0) (0x00502223) -> write=1 exactly one cycle (cycle 4) with pc_write=1; RegWrite never 1.
//  beq x1,x2,+8 (0x00208463): status=4'b0001 -> PCSrc=1, pc_write=1 in cycle 3; status=0 -> PCSrc=0; op=1.
//  inst_in=0xFFFFFFFF -> TRAP after DECODE, illegal=1, no enables for 20 cycles; reset low -> FETCH, illegal=0.
//  run=0 for 5 cycles in FETCH -> no state change; reset pulsed during LW MEM -> RegWrite never asserted.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for an RV32I-subset datapath. It sequences FETCH/DECODE/EXEC/MEM/WB,
// decodes datapath controls from the latched instruction and traps on unsupported encodings.
module multicycle_control #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] inst_in,
  input  logic [3:0]  status,
  output logic        RegWrite,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic [4:0]  ALU_operation,
  output logic        write,
  output logic        MemtoReg,
  output logic        pc_write,
  output logic        retired,
  output logic        illegal
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;

  localparam logic [3:0] MEM_LAST = 4'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] ir;
  logic [3:0]  mem_cnt, mem_cnt_nxt;

  function automatic logic is_supported(input logic [6:0] opcode, input logic [2:0] funct3,
                                        input logic [6:0] funct7);
    logic ok;
    ok = 1'b0;
    case (opcode)
      OPC_R:      ok = (funct7 == 7'b0000000) ||
                       (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
      OPC_I:      ok = 1'b1;
      OPC_LOAD:   ok = (funct3 == 3'b010);
      OPC_STORE:  ok = (funct3 == 3'b010);
      OPC_BRANCH: ok = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                       (funct3 == 3'b100) || (funct3 == 3'b101);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // alt is instruction bit 30: selects SUB (R-type only) and SRA (R and I shifts).
  function automatic logic [4:0] alu_op(input logic r_type, input logic [2:0] funct3, input logic alt);
    logic [4:0] op;
    case (funct3)
      3'b000:  op = (r_type && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_load, is_store, is_branch;
  logic [4:0] ir_alu_op;
  logic       ir_alu_src;
  logic       flag_z, flag_n, flag_v, taken;
  logic       unused_bits;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign is_r      = (opcode == OPC_R);
  assign is_i      = (opcode == OPC_I);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);

  assign ir_alu_op  = is_branch             ? ALU_SUB :
                      (is_load || is_store) ? ALU_ADD : alu_op(is_r, funct3, ir[30]);
  assign ir_alu_src = is_i || is_load || is_store;

  assign flag_z = status[0];
  assign flag_n = status[1];
  assign flag_v = status[3];

  always_comb begin
    case (funct3)
      3'b000:  taken = flag_z;
      3'b001:  taken = !flag_z;
      3'b100:  taken = flag_n ^ flag_v;
      default: taken = !(flag_n ^ flag_v);
    endcase
  end

  assign unused_bits = ^{ir[31], ir[29:15], ir[11:7], inst_in[24:15], inst_in[11:7], status[2]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      ir      <= '0;
      mem_cnt <= '0;
    end else begin
      state   <= state_nxt;
      mem_cnt <= mem_cnt_nxt;
      if (state == S_DECODE) ir <= inst_in;
    end
  end

  // NOTE: every combinational output is defaulted first so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    mem_cnt_nxt   = '0;
    RegWrite      = 1'b0;
    PCSrc         = 1'b0;
    ALUSrc        = 1'b0;
    ALU_operation = ALU_ADD;
    write         = 1'b0;
    MemtoReg      = 1'b0;
    pc_write      = 1'b0;
    retired       = 1'b0;
    illegal       = 1'b0;

    case (state)
      S_FETCH: if (run) state_nxt = S_DECODE;

      S_DECODE: state_nxt = is_supported(inst_in[6:0], inst_in[14:12], inst_in[31:25]) ? S_EXEC : S_TRAP;

      S_EXEC: begin
        ALU_operation = ir_alu_op;
        ALUSrc        = ir_alu_src;
        if (is_r || is_i) begin
          state_nxt = S_WB;
        end else if (is_load || is_store) begin
          state_nxt = S_MEM;
        end else if (is_branch) begin
          PCSrc     = taken;
          pc_write  = 1'b1;
          retired   = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_TRAP;
        end
      end

      S_MEM: begin
        ALU_operation = ir_alu_op;
        ALUSrc        = ir_alu_src;
        if (is_store) begin
          write     = 1'b1;
          pc_write  = 1'b1;
          retired   = 1'b1;
          state_nxt = S_FETCH;
        end else if (mem_cnt == MEM_LAST) begin
          state_nxt = S_WB;
        end else begin
          mem_cnt_nxt = mem_cnt + 4'd1;
        end
      end

      S_WB: begin
        ALU_operation = ir_alu_op;
        ALUSrc        = ir_alu_src;
        RegWrite      = 1'b1;
        MemtoReg      = !is_load;
        pc_write      = 1'b1;
        retired       = 1'b1;
        state_nxt     = S_FETCH;
      end

      S_TRAP: illegal = 1'b1;

      default: state_nxt = S_TRAP;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: stimulus pushes the expected retirement record,
// a negedge monitor pops and compares whenever the DUT retires, and polices idle/trap/reset cycles.
module tb_multicycle_control;

  localparam int MEM_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [31:0] inst_in = '0;
  logic [3:0]  status = '0;
  logic        RegWrite, PCSrc, ALUSrc, write, MemtoReg, pc_write, retired, illegal;
  logic [4:0]  ALU_operation;

  multicycle_control #(.MEM_LAT(MEM_LAT)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .run           (run),
    .inst_in       (inst_in),
    .status        (status),
    .RegWrite      (RegWrite),
    .PCSrc         (PCSrc),
    .ALUSrc        (ALUSrc),
    .ALU_operation (ALU_operation),
    .write         (write),
    .MemtoReg      (MemtoReg),
    .pc_write      (pc_write),
    .retired       (retired),
    .illegal       (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pcsrc;
    logic       regwrite;
    logic       memtoreg;
    logic       write;
    logic       alusrc;
    logic [4:0] op;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic expect_trap = 1'b0;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: what one instruction must show at its retirement, from the ISA-level rules.
  function automatic exp_t model(input logic [31:0] ins, input logic [3:0] st, input int stall,
                                 output bit legal);
    exp_t e;
    int   plain_op[8] = '{0, 5, 8, 9, 4, 6, 3, 2};  // ADD SLL SLT SLTU XOR SRL OR AND by funct3
    int   f3 = int'(ins[14:12]);
    int   f7 = int'(ins[31:25]);
    bit   alt = ins[30];
    bit   lt = st[1] ^ st[3];
    e = '{pcsrc: 0, regwrite: 0, memtoreg: 0, write: 0, alusrc: 0, op: 0, lat: 0};
    legal = 0;
    case (ins[6:0])
      7'h33: begin
        legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        e.op = 5'(plain_op[f3]);
        if (alt && f3 == 0) e.op = 5'd1;
        if (alt && f3 == 5) e.op = 5'd7;
        e.regwrite = 1; e.memtoreg = 1; e.lat = 4;
      end
      7'h13: begin
        legal = 1;
        e.op = 5'(plain_op[f3]);
        if (alt && f3 == 5) e.op = 5'd7;
        e.regwrite = 1; e.memtoreg = 1; e.alusrc = 1; e.lat = 4;
      end
      7'h03: begin
        legal = (f3 == 2);
        e.regwrite = 1; e.alusrc = 1; e.lat = 4 + MEM_LAT;
      end
      7'h23: begin
        legal = (f3 == 2);
        e.write = 1; e.alusrc = 1; e.lat = 4;
      end
      7'h63: begin
        legal = (f3 == 0 || f3 == 1 || f3 == 4 || f3 == 5);
        e.op = 5'd1; e.lat = 3;
        case (f3)
          0:       e.pcsrc = st[0];
          1:       e.pcsrc = !st[0];
          4:       e.pcsrc = lt;
          default: e.pcsrc = !lt;
        endcase
      end
      default: legal = 0;
    endcase
    e.lat += stall;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0;
      check("reset_outputs", 32'({RegWrite, PCSrc, ALUSrc, ALU_operation, write, MemtoReg,
                                  pc_write, retired, illegal}), 32'd0);
    end else begin
      cyc++;
      check("pc_write_vs_retired", 32'(pc_write), 32'(retired));
      check("illegal", 32'(illegal), 32'(expect_trap));
      if (retired) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: got retire with nothing outstanding (t=%0t)", $time);
        end else begin
          mon_e = sb.pop_front();
          check("PCSrc", 32'(PCSrc), 32'(mon_e.pcsrc));
          check("RegWrite", 32'(RegWrite), 32'(mon_e.regwrite));
          check("MemtoReg", 32'(MemtoReg), 32'(mon_e.memtoreg));
          check("write", 32'(write), 32'(mon_e.write));
          check("ALUSrc", 32'(ALUSrc), 32'(mon_e.alusrc));
          check("ALU_operation", 32'(ALU_operation), 32'(mon_e.op));
          check("latency", 32'(cyc), 32'(mon_e.lat));
        end
        cyc = 0;
      end else begin
        check("idle_enables", 32'({RegWrite, write, PCSrc}), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    expect_trap = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Called at the start of a FETCH cycle; returns at the start of the next FETCH cycle.
  task automatic run_instr(input logic [31:0] ins, input logic [3:0] st, input int stall);
    exp_t e;
    bit   legal;
    int   n;
    e = model(ins, st, stall, legal);
    inst_in = ins;
    status  = st;
    if (legal) sb.push_back(e);
    run = 1'b0;
    for (int k = 0; k < stall; k++) tick();
    run = 1'b1;
    tick();
    run = 1'($urandom_range(0, 1));
    if (!legal) begin
      tick();
      expect_trap = 1'b1;
      repeat (20) tick();
      do_reset();
    end else begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!retired && n < 40);
      if (!retired) begin
        checks++;
        errors++;
        $display("FAIL retire_timeout: got no retire within 40 cycles for 0x%08h", ins);
        sb.delete();
        tick();
        do_reset();
      end else begin
        tick();
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [2:0]  br_f3[4] = '{3'b000, 3'b001, 3'b100, 3'b101};
    int          cls = $urandom_range(0, 9);
    w = $urandom;
    case (cls)
      0, 1: begin
        w[6:0] = 7'h33;
        if ($urandom_range(0, 9) == 0) w[31:25] = 7'($urandom);
        else if ((w[14:12] == 3'b000 || w[14:12] == 3'b101) && w[0 +: 1] == 1'b1 && $urandom_range(0, 1) == 1)
          w[31:25] = 7'b0100000;
        else w[31:25] = 7'b0000000;
      end
      2, 3: w[6:0] = 7'h13;
      4: begin w[6:0] = 7'h03; if ($urandom_range(0, 7) != 0) w[14:12] = 3'b010; end
      5: begin w[6:0] = 7'h23; if ($urandom_range(0, 7) != 0) w[14:12] = 3'b010; end
      6, 7: begin w[6:0] = 7'h63; if ($urandom_range(0, 7) != 0) w[14:12] = br_f3[$urandom_range(0, 3)]; end
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    run_instr(32'h002081B3, 4'b0000, 0);  // add x3,x1,x2
    run_instr(32'h40208133, 4'b0000, 0);  // sub x2,x1,x2
    run_instr(32'h00802283, 4'b0000, 0);  // lw x5,8(x0)
    run_instr(32'h00502223, 4'b0000, 0);  // sw x5,4(x0)
    run_instr(32'h00208463, 4'b0001, 0);  // beq taken
    run_instr(32'h00208463, 4'b0000, 0);  // beq not taken
    run_instr(32'h0020C463, 4'b1000, 0);  // blt with V=1, N=0
    run_instr(32'h002081B3, 4'b0000, 5);  // held in FETCH by run=0
    run_instr(32'hFFFFFFFF, 4'b0000, 0);  // traps
    run_instr(32'h00000000, 4'b0000, 0);  // zero word traps

    // Reset pulsed while a load sits in MEM: nothing may retire.
    inst_in = 32'h00802283;
    run = 1'b1;
    tick();
    tick();
    tick();
    do_reset();
    run_instr(32'h002081B3, 4'b0000, 5);

    for (int i = 0; i < 200; i++)
      run_instr(rand_instr(), 4'($urandom), ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
